// File: rtl/lfsr_burst_gen.sv
// Parametrised Fibonacci LFSR with seed load, lock-up protection, EN-gated free-run
// and counted burst mode with busy/done handshake and period-wrap flag.
module lfsr_burst_gen #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(4'b0001),
    parameter bit               XNOR_FB = 1'b0,
    parameter int unsigned      LEN_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED_IN,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             lockup
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The single state the feedback function maps onto itself.
    localparam logic [WIDTH-1:0] LOCKUP_VAL = {WIDTH{XNOR_FB}};

    logic [1:0]       state_q;
    logic [WIDTH-1:0] ref_seed_q;
    logic [LEN_W-1:0] remaining_q;

    logic [1:0]       state_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] ref_seed_d;
    logic [LEN_W-1:0] remaining_d;
    logic             step_d;
    logic             lockup_d;
    logic             fb_c;
    logic [WIDTH-1:0] step_val_c;

    assign fb_c       = (^(out & TAPS)) ^ XNOR_FB;
    assign step_val_c = {out[WIDTH-2:0], fb_c};

    // Next-state and stepping decision; LOAD overrides the FSM in any state.
    always_comb begin
        state_d     = state_q;
        out_d       = out;
        ref_seed_d  = ref_seed_q;
        remaining_d = remaining_q;
        step_d      = 1'b0;
        lockup_d    = 1'b0;

        if (LOAD) begin
            state_d = ST_IDLE;
            if (SEED_IN == LOCKUP_VAL) begin
                out_d      = SEED;
                ref_seed_d = SEED;
                lockup_d   = 1'b1;
            end else begin
                out_d      = SEED_IN;
                ref_seed_d = SEED_IN;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (LEN != '0) begin
                            state_d     = ST_RUN;
                            remaining_d = LEN;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (EN) begin
                        step_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (EN) begin
                        step_d      = 1'b1;
                        remaining_d = remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (step_d) begin
                out_d = step_val_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            out         <= SEED;
            ref_seed_q  <= SEED;
            remaining_q <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrap        <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out         <= out_d;
            ref_seed_q  <= ref_seed_d;
            remaining_q <= remaining_d;
            out_valid   <= step_d;
            busy        <= (state_d == ST_RUN);
            done        <= (state_d == ST_DONE);
            wrap        <= step_d && (step_val_c == ref_seed_q);
            lockup      <= lockup_d;
        end
    end

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Self-checking bench for lfsr_burst_gen: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_lfsr_burst_gen;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned LEN_W = 8;
    localparam logic [3:0]  TAPS  = 4'b1100;
    localparam logic [3:0]  SEED  = 4'b0001;

    logic             CLK = 1'b0;
    logic             RST, EN, LOAD, START;
    logic [WIDTH-1:0] SEED_IN;
    logic [LEN_W-1:0] LEN;
    logic [WIDTH-1:0] out;
    logic             out_valid, busy, done, wrap, lockup;

    lfsr_burst_gen #(
        .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .XNOR_FB(1'b0), .LEN_W(LEN_W)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .SEED_IN(SEED_IN),
        .START(START), .LEN(LEN), .out(out), .out_valid(out_valid),
        .busy(busy), .done(done), .wrap(wrap), .lockup(lockup)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int pass_cnt = 0;

    // Behavioural model: mode 0 = idle, 1 = burst running, 2 = burst-complete cycle.
    int         m_mode;
    int         m_left;
    logic [3:0] m_out, m_ref;
    logic       e_valid, e_busy, e_done, e_wrap, e_lockup;

    function automatic logic [3:0] next_val(input logic [3:0] s);
        int ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (TAPS[i] && s[i]) ones++;
        end
        return 4'((int'(s) * 2 + ones % 2) % 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model(input logic r, input logic e, input logic l, input logic [3:0] si,
                         input logic st, input int ln);
        logic stepped = 1'b0;
        e_lockup = 1'b0;
        if (r) begin
            m_out = SEED; m_ref = SEED; m_mode = 0; m_left = 0;
        end else if (l) begin
            if (si == 4'd0) begin
                m_out = SEED; m_ref = SEED; e_lockup = 1'b1;
            end else begin
                m_out = si; m_ref = si;
            end
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                if (ln > 0) begin m_mode = 1; m_left = ln; end
                else m_mode = 2;
            end else if (e) begin
                stepped = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (e) begin
                stepped = 1'b1;
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
        if (stepped) m_out = next_val(m_out);
        e_valid = stepped;
        e_wrap  = stepped && (m_out == m_ref);
        e_busy  = (m_mode == 1);
        e_done  = (m_mode == 2);
    endtask

    // One clock: drive inputs, advance model, sample after the edge and compare.
    task automatic cycle(input logic r, input logic e, input logic l, input logic [3:0] si,
                         input logic st, input int ln);
        RST = r; EN = e; LOAD = l; SEED_IN = si; START = st; LEN = LEN_W'(ln);
        model(r, e, l, si, st, ln);
        @(posedge CLK);
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("wrap", 32'(wrap), 32'(e_wrap));
        chk("lockup", 32'(lockup), 32'(e_lockup));
    endtask

    logic [3:0] seq [15];

    initial begin
        seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
        m_mode = 0; m_left = 0; m_out = SEED; m_ref = SEED;

        // Reset
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_out", 32'(out), 32'h1);

        // Free-run full period
        for (int i = 0; i < 15; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            chk("freerun_seq", 32'(out), 32'(seq[i]));
            chk("freerun_wrap", 32'(wrap), (i == 14) ? 32'd1 : 32'd0);
        end

        // Burst of 5
        cycle(0, 1, 0, 0, 1, 5);
        chk("burst_start_hold", 32'(out), 32'h1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        chk("burst_end_out", 32'(out), 32'h6);
        chk("burst_done", 32'(done), 32'h1);
        cycle(0, 1, 0, 0, 0, 0);
        chk("burst_done_idle_hold", 32'(out), 32'h6);

        // Burst with EN pause
        cycle(0, 0, 1, 4'b0001, 0, 0);
        cycle(0, 0, 0, 0, 1, 5);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("pause_hold", 32'(out), 32'h4);
        chk("pause_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
        chk("pause_end_out", 32'(out), 32'h6);
        cycle(0, 0, 0, 0, 0, 0);

        // Lock-up load, then abort a burst with LOAD
        cycle(0, 0, 1, 4'b0000, 0, 0);
        chk("lockup_out", 32'(out), 32'h1);
        chk("lockup_flag", 32'(lockup), 32'h1);
        cycle(0, 0, 0, 0, 1, 10);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 4'b1010, 0, 0);
        chk("abort_out", 32'(out), 32'ha);
        chk("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0, 0, 0);
        chk("load_wrap", 32'(wrap), 32'h1);
        chk("load_wrap_out", 32'(out), 32'ha);

        // Reset mid-burst, then zero-length burst
        cycle(0, 0, 0, 0, 1, 5);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        chk("rst_mid_out", 32'(out), 32'h1);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0);
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_out", 32'(out), 32'h1);
        cycle(0, 1, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, e, l, st;
            logic [3:0] si;
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 3) != 0);
            si = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            cycle(r, e, l, si, st, int'($urandom_range(0, 12)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
